// File: rtl/qpsk_mapper.sv
// ---------------------------------------------------------------------------
// qpsk_mapper : pairs serial interleaver bits into Gray-coded QPSK Q1.15 I/Q
//               samples behind a 2-entry valid/ready FIFO with block flags.
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module qpsk_mapper #(
    parameter int BLOCK_BITS = 192,
    parameter int DATA_W     = 16,
    parameter int AMP        = 23170
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              valid_in,
    input  logic              data_in,
    output logic              ready_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [DATA_W-1:0] i_out,
    output logic [DATA_W-1:0] q_out,
    output logic              sym_first,
    output logic              sym_last
);

    localparam int                SYMS       = BLOCK_BITS / 2;
    localparam int                IDX_W      = (SYMS > 1) ? $clog2(SYMS) : 1;
    localparam logic [0:0]        S_IDLE     = 1'b0;
    localparam logic [0:0]        S_RUN      = 1'b1;
    localparam logic [DATA_W-1:0] C_POS      = DATA_W'(AMP);
    localparam logic [DATA_W-1:0] C_NEG      = DATA_W'(-AMP);
    localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(SYMS - 1);

    logic [0:0]                   state_q, state_d;
    logic                         pair_phase_q, pair_phase_d;
    logic                         b0_q, b0_d;
    logic [IDX_W-1:0]             sym_idx_q, sym_idx_d;
    logic [1:0]                   count_q, count_d;
    logic                         rd_ptr_q, rd_ptr_d;
    logic                         wr_ptr_q, wr_ptr_d;
    logic [1:0][DATA_W-1:0]       mem_i_q, mem_i_d;
    logic [1:0][DATA_W-1:0]       mem_q_q, mem_q_d;
    logic [1:0]                   first_q, first_d;
    logic [1:0]                   last_q, last_d;

    logic                         w_accept;
    logic                         w_push;
    logic                         w_pop;

    // State register
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE lasts exactly one cycle after reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready_out = 1'b0;
        if (state_q == S_RUN) begin
            ready_out = (count_q != 2'd2);
        end
    end

    assign w_accept  = valid_in && ready_out;
    assign w_push    = w_accept && pair_phase_q;
    assign valid_out = (count_q != 2'd0);
    assign w_pop     = valid_out && ready_in;

    assign i_out     = valid_out ? mem_i_q[rd_ptr_q] : '0;
    assign q_out     = valid_out ? mem_q_q[rd_ptr_q] : '0;
    assign sym_first = valid_out && first_q[rd_ptr_q];
    assign sym_last  = valid_out && last_q[rd_ptr_q];

    always_comb begin
        pair_phase_d = pair_phase_q;
        b0_d         = b0_q;
        sym_idx_d    = sym_idx_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        mem_i_d      = mem_i_q;
        mem_q_d      = mem_q_q;
        first_d      = first_q;
        last_d       = last_q;

        if (w_accept) begin
            b0_d         = pair_phase_q ? b0_q : data_in;
            pair_phase_d = ~pair_phase_q;
        end

        // Gray mapping is resolved at push time so the FIFO holds final samples
        if (w_push) begin
            mem_i_d[wr_ptr_q] = b0_q    ? C_NEG : C_POS;
            mem_q_d[wr_ptr_q] = data_in ? C_NEG : C_POS;
            first_d[wr_ptr_q] = (sym_idx_q == '0);
            last_d[wr_ptr_q]  = (sym_idx_q == C_LAST_IDX);
            wr_ptr_d          = ~wr_ptr_q;
            sym_idx_d         = (sym_idx_q == C_LAST_IDX) ? '0 : sym_idx_q + IDX_W'(1);
        end

        if (w_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            pair_phase_q <= 1'b0;
            b0_q         <= 1'b0;
            sym_idx_q    <= '0;
            count_q      <= 2'd0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            mem_i_q      <= '0;
            mem_q_q      <= '0;
            first_q      <= 2'b00;
            last_q       <= 2'b00;
        end else begin
            pair_phase_q <= pair_phase_d;
            b0_q         <= b0_d;
            sym_idx_q    <= sym_idx_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            mem_i_q      <= mem_i_d;
            mem_q_q      <= mem_q_d;
            first_q      <= first_d;
            last_q       <= last_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_qpsk_mapper.sv
// ---------------------------------------------------------------------------
// tb_qpsk_mapper : directed self-checking bench for qpsk_mapper.
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_qpsk_mapper;

    localparam logic [15:0] POS = 16'h5A82;
    localparam logic [15:0] NEG = 16'hA57E;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        valid_in = 1'b0;
    logic        data_in = 1'b0;
    logic        ready_out;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic [15:0] i_out;
    logic [15:0] q_out;
    logic        sym_first;
    logic        sym_last;

    int n_pass  = 0;
    int n_total = 0;

    qpsk_mapper #(
        .BLOCK_BITS(192),
        .DATA_W    (16),
        .AMP       (23170)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .valid_in (valid_in),
        .data_in  (data_in),
        .ready_out(ready_out),
        .valid_out(valid_out),
        .ready_in (ready_in),
        .i_out    (i_out),
        .q_out    (q_out),
        .sym_first(sym_first),
        .sym_last (sym_last)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset and release; returns one cycle after release with the DUT in RUN
    task automatic do_reset;
        resetN   = 1'b0;
        valid_in = 1'b0;
        data_in  = 1'b0;
        ready_in = 1'b1;
        tick();
        tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        logic [35:0] got;
        resetN   = 1'b0;
        valid_in = 1'b1;
        data_in  = 1'b1;
        ready_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            got = {ready_out, valid_out, i_out, q_out, sym_first, sym_last};
            n_total++;
            if (got !== 36'd0) $display("FAIL reset_outputs cycle %0d: got %h want 0", c, got);
            else n_pass++;
        end
        resetN = 1'b1;
        #1;
        n_total++;
        if (ready_out !== 1'b0) $display("FAIL idle_ready_out: got %b want 0", ready_out);
        else n_pass++;
        tick();
        n_total++;
        if (ready_out !== 1'b1) $display("FAIL run_ready_out: got %b want 1", ready_out);
        else n_pass++;
        n_total++;
        if (valid_out !== 1'b0) $display("FAIL idle_no_accept: valid_out got %b want 0", valid_out);
        else n_pass++;
        valid_in = 1'b0;
        tick();
        n_total++;
        if (valid_out !== 1'b0) $display("FAIL idle_no_symbol: valid_out got %b want 0", valid_out);
        else n_pass++;
    endtask

    task automatic test_mapping;
        logic [15:0] ei [4];
        logic [15:0] eq [4];
        logic [33:0] got, exp;
        ei = '{POS, POS, NEG, NEG};
        eq = '{POS, NEG, POS, NEG};
        do_reset();
        for (int p = 0; p < 4; p++) begin
            valid_in = 1'b1;
            data_in  = (p >= 2);
            tick();
            if (p == 0) begin
                n_total++;
                if (valid_out !== 1'b0) $display("FAIL map_half_pair: valid_out got %b want 0", valid_out);
                else n_pass++;
            end
            data_in = p[0];
            tick();
            got = {valid_out, i_out, q_out, sym_first};
            exp = {1'b1, ei[p], eq[p], (p == 0)};
            n_total++;
            if (got !== exp) $display("FAIL map_pair%0d: got %h want %h", p, got, exp);
            else n_pass++;
        end
        valid_in = 1'b0;
        tick();
        n_total++;
        if (valid_out !== 1'b0) $display("FAIL map_drained: valid_out got %b want 0", valid_out);
        else n_pass++;
    endtask

    task automatic test_full_block;
        logic        bit_v;
        logic        b0;
        int          sym;
        int          seen;
        logic [35:0] got, exp;
        do_reset();
        seen = 0;
        b0   = 1'b0;
        for (int k = 0; k < 384; k++) begin
            bit_v    = 1'($urandom_range(0, 1));
            valid_in = 1'b1;
            data_in  = bit_v;
            if (k % 2 == 0) b0 = bit_v;
            tick();
            if (k % 2 == 1) begin
                sym = (k / 2) % 96;
                got = {ready_out, valid_out, i_out, q_out, sym_first, sym_last};
                exp = {1'b1, 1'b1, (b0 ? NEG : POS), (bit_v ? NEG : POS), (sym == 0), (sym == 95)};
                n_total++;
                if (got !== exp) $display("FAIL block_sym%0d (bit %0d): got %h want %h", sym, k, got, exp);
                else n_pass++;
            end
            if (valid_out) seen++;
        end
        valid_in = 1'b0;
        tick();
        n_total++;
        if (seen !== 192) $display("FAIL block_sym_count: got %0d want 192", seen);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [34:0] got;
        logic [34:0] s0, s1, s2;
        s0 = {1'b1, NEG, POS, 1'b1, 1'b0};
        s1 = {1'b1, POS, NEG, 1'b0, 1'b0};
        s2 = {1'b1, NEG, NEG, 1'b0, 1'b0};
        do_reset();
        ready_in = 1'b0;
        valid_in = 1'b1;
        data_in  = 1'b1; tick();
        data_in  = 1'b0; tick();
        got = {valid_out, i_out, q_out, sym_first, sym_last};
        n_total++;
        if (got !== s0) $display("FAIL bp_head_sym0: got %h want %h", got, s0);
        else n_pass++;
        data_in = 1'b0; tick();
        data_in = 1'b1; tick();
        n_total++;
        if (ready_out !== 1'b0) $display("FAIL bp_full_ready: got %b want 0", ready_out);
        else n_pass++;
        data_in = 1'b1;
        tick();
        tick();
        got = {valid_out, i_out, q_out, sym_first, sym_last};
        n_total++;
        if ({ready_out, got} !== {1'b0, s0}) $display("FAIL bp_stall_hold: got %b/%h want 0/%h", ready_out, got, s0);
        else n_pass++;
        ready_in = 1'b1;
        tick();
        got = {valid_out, i_out, q_out, sym_first, sym_last};
        n_total++;
        if ({ready_out, got} !== {1'b1, s1}) $display("FAIL bp_drain_sym1: got %b/%h want 1/%h", ready_out, got, s1);
        else n_pass++;
        tick();
        n_total++;
        if (valid_out !== 1'b0) $display("FAIL bp_drain_empty: valid_out got %b want 0", valid_out);
        else n_pass++;
        data_in = 1'b1;
        tick();
        got = {valid_out, i_out, q_out, sym_first, sym_last};
        n_total++;
        if (got !== s2) $display("FAIL bp_sym2: got %h want %h", got, s2);
        else n_pass++;
        valid_in = 1'b0;
        tick();
        n_total++;
        if (valid_out !== 1'b0) $display("FAIL bp_no_dup: valid_out got %b want 0", valid_out);
        else n_pass++;
    endtask

    task automatic test_simultaneous;
        logic [33:0] got, exp;
        do_reset();
        ready_in = 1'b0;
        valid_in = 1'b1;
        data_in  = 1'b0; tick();
        data_in  = 1'b0; tick();
        data_in  = 1'b1; tick();
        ready_in = 1'b1;
        data_in  = 1'b0;
        tick();
        got = {ready_out, valid_out, i_out, q_out};
        exp = {1'b1, 1'b1, NEG, POS};
        n_total++;
        if (got !== exp) $display("FAIL simul_head: got %h want %h", got, exp);
        else n_pass++;
        valid_in = 1'b0;
        tick();
        n_total++;
        if (valid_out !== 1'b0) $display("FAIL simul_count_one: valid_out got %b want 0", valid_out);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [34:0] got, exp;
        do_reset();
        valid_in = 1'b1;
        for (int k = 0; k < 101; k++) begin
            if (k == 98) ready_in = 1'b0;
            data_in = 1'($urandom_range(0, 1));
            tick();
        end
        n_total++;
        if (valid_out !== 1'b1) $display("FAIL mid_pre_fifo: valid_out got %b want 1", valid_out);
        else n_pass++;
        resetN   = 1'b0;
        valid_in = 1'b0;
        tick();
        n_total++;
        if ({ready_out, valid_out} !== 2'b00) $display("FAIL mid_in_reset: got %b want 00", {ready_out, valid_out});
        else n_pass++;
        resetN   = 1'b1;
        ready_in = 1'b1;
        tick();
        n_total++;
        if ({ready_out, valid_out} !== 2'b10) $display("FAIL mid_after_reset: got %b want 10", {ready_out, valid_out});
        else n_pass++;
        valid_in = 1'b1;
        data_in  = 1'b1;
        tick();
        n_total++;
        if (valid_out !== 1'b0) $display("FAIL mid_first_is_b0: valid_out got %b want 0", valid_out);
        else n_pass++;
        tick();
        got = {valid_out, i_out, q_out, sym_first, sym_last};
        exp = {1'b1, NEG, NEG, 1'b1, 1'b0};
        n_total++;
        if (got !== exp) $display("FAIL mid_first_sym: got %h want %h", got, exp);
        else n_pass++;
        valid_in = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_mapping();
        test_full_block();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
